exp_rom_loader: RTL and testbench



---
 rtl/cpc_loader_pkg.sv | 25 ++
 rtl/ext_page_decode.sv | 33 +++
 rtl/exp_rom_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_exp_rom_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_loader_pkg.sv
// Shared types and constants for the CPC expansion/system ROM loader.
// Holds the loader FSM encoding, the system-ROM slot table and ASCII hex decode.
package cpc_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WRITE = 2'd2,
    ST_NEXT  = 2'd3
  } state_t;

  localparam logic [8:0] BAD_PAGE_DEF = 9'h1EE;
  localparam logic [8:0] MF2_PAGE_DEF = 9'h1FF;

  // System ROM 16 KB slot (mod 4) -> page; entry 3 is replaced by the MF2_PAGE parameter.
  localparam logic [8:0] SLOT_PAGE [4] = '{9'h000, 9'h100, 9'h107, MF2_PAGE_DEF};

  // Returns {valid, nibble} for an upper-case ASCII hex digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    else return 5'b0_0000;
  endfunction

endpackage

// File: rtl/ext_page_decode.sv
// Maps the last two ASCII characters of a ROM file extension to an upper-ROM page.
// Each hex character overrides one nibble of BAD_PAGE; only a fully valid pair leaves the bad region.
module ext_page_decode
  import cpc_loader_pkg::*;
#(
  parameter logic [8:0] BAD_PAGE = BAD_PAGE_DEF
) (
  input  logic [15:0] file_ext,
  output logic [8:0]  page,
  output logic        combo
);

  logic [4:0] hi_nib;
  logic [4:0] lo_nib;

  always_comb begin
    hi_nib = hex_nib(file_ext[15:8]);
    lo_nib = hex_nib(file_ext[7:0]);
    page   = BAD_PAGE;
    combo  = 1'b0;
    if (hi_nib[4]) page[7:4] = hi_nib[3:0];
    if (lo_nib[4]) page[3:0] = lo_nib[3:0];
    if (hi_nib[4] && lo_nib[4]) page[8] = 1'b0;
    // "ZZ" is a plain page-0 image, "Z0" is page 0 followed by the MF2 image.
    if (file_ext == 16'h5A5A) begin
      page = 9'h000;
    end else if (file_ext == 16'h5A30) begin
      page  = 9'h000;
      combo = 1'b1;
    end
  end

endmodule

// File: rtl/exp_rom_loader.sv
// Streams HPS ROM downloads into SDRAM, mirroring each byte into one or more banks,
// and records which upper-ROM pages were loaded in a small presence map.
module exp_rom_loader
  import cpc_loader_pkg::*;
#(
  parameter int         NUM_BANKS = 2,
  parameter int         PAGE_BITS = 8,
  parameter logic [8:0] BAD_PAGE  = BAD_PAGE_DEF,
  parameter logic [8:0] MF2_PAGE  = MF2_PAGE_DEF
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         ce_ref,
  input  logic                         ioctl_download,
  input  logic                         ioctl_wr,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  input  logic [7:0]                   ioctl_index,
  input  logic [15:0]                  ioctl_file_ext,
  input  logic [NUM_BANKS-1:0]         bank_mirror,
  output logic                         ioctl_wait,
  output logic                         boot_wr,
  output logic [PAGE_BITS+14:0]        boot_a,
  output logic [$clog2(NUM_BANKS)-1:0] boot_bank,
  output logic [7:0]                   boot_dout,
  input  logic [PAGE_BITS-1:0]         map_addr,
  output logic                         map_hit,
  output logic                         load_done,
  output state_t                       dbg_state
);

  localparam int AW        = PAGE_BITS + 15;
  localparam int BW        = $clog2(NUM_BANKS);
  localparam int PW        = PAGE_BITS + 1;
  localparam int MAP_DEPTH = 2 ** PAGE_BITS;

  // Handshake: the HPS presents a byte with ioctl_wr while ioctl_download is high; the
  // byte is taken only in IDLE, ioctl_wait rises the next cycle and falls in the cycle
  // the last bank write retires. The HPS holds off further bytes while ioctl_wait is high.

  state_t               state_q, state_d;
  logic [PW-1:0]        page_q, page_d;
  logic                 combo_q, combo_d;
  logic [PAGE_BITS-1:0] base_q, base_d;
  logic [PAGE_BITS-1:0] addr_pg_q, addr_pg_d;
  logic                 dl_q;
  logic                 load_done_q, load_done_d;
  logic                 wait_q, wait_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        boot_a_q, boot_a_d;
  logic [7:0]           dout_q, dout_d;
  logic [BW-1:0]        bank_q, bank_d;
  logic [NUM_BANKS-1:0] mirror_q, mirror_d;

  logic                 map_mem [MAP_DEPTH];
  logic                 map_hit_q;
  logic                 map_we;
  logic [PAGE_BITS-1:0] map_waddr;

  logic [8:0]           ext_page;
  logic                 ext_combo;
  logic                 dl_rise, new_ext, sys_rom, slot_ok, use_mirror, accept, has_next;
  logic [PW-1:0]        cur_page;
  logic [PAGE_BITS-1:0] cur_base, offs_pg;
  logic [10:0]          slot;
  logic [8:0]           slot_pg;
  logic [NUM_BANKS-1:0] set_new;
  logic [BW-1:0]        first_bank, next_bank;

  ext_page_decode #(.BAD_PAGE(BAD_PAGE)) u_ext_page_decode (
    .file_ext (ioctl_file_ext),
    .page     (ext_page),
    .combo    (ext_combo)
  );

  always_comb begin
    dl_rise    = ioctl_download & ~dl_q;
    new_ext    = dl_rise & (ioctl_index != 8'd0);
    cur_page   = new_ext ? PW'(ext_page) : page_q;
    cur_base   = dl_rise ? '0 : base_q;
    slot       = ioctl_addr[24:14];
    sys_rom    = (ioctl_index == 8'd0);
    slot_ok    = int'(slot) < 4 * NUM_BANKS;
    slot_pg    = (slot[1:0] == 2'd3) ? MF2_PAGE : SLOT_PAGE[slot[1:0]];
    use_mirror = (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);
    // An empty mirror selection falls back to bank 0 so the byte is never lost.
    set_new = NUM_BANKS'(1);
    if (sys_rom) begin
      set_new = '0;
      set_new[slot[2 +: BW]] = 1'b1;
    end else if (use_mirror && (bank_mirror != '0)) begin
      set_new = bank_mirror;
    end
    first_bank = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (set_new[i]) first_bank = BW'(i);
    end
    next_bank = bank_q;
    has_next  = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (mirror_q[i] && (i > int'(bank_q))) begin
        next_bank = BW'(i);
        has_next  = 1'b1;
      end
    end
    // base is non-zero only for the MF2 half of a combo file, so it restarts at offset 0.
    offs_pg = cur_page[PAGE_BITS-1:0] + ioctl_addr[14 +: PAGE_BITS] - cur_base;
    accept  = ioctl_download & ioctl_wr & (~sys_rom | slot_ok);

    state_d     = state_q;
    page_d      = cur_page;
    combo_d     = new_ext ? ext_combo : combo_q;
    base_d      = cur_base;
    addr_pg_d   = addr_pg_q;
    wait_d      = wait_q;
    wr_d        = wr_q;
    boot_a_d    = boot_a_q;
    dout_d      = dout_q;
    bank_d      = bank_q;
    mirror_d    = mirror_q;
    map_we      = 1'b0;
    map_waddr   = boot_a_q[PAGE_BITS+13:14];
    load_done_d = dl_q & ~ioctl_download;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          boot_a_d  = sys_rom ? {PW'(slot_pg), ioctl_addr[13:0]}
                              : {cur_page[PW-1], offs_pg, ioctl_addr[13:0]};
          dout_d    = ioctl_dout;
          mirror_d  = set_new;
          bank_d    = first_bank;
          addr_pg_d = ioctl_addr[14 +: PAGE_BITS];
          wait_d    = 1'b1;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (ce_ref) begin
          wr_d    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ce_ref) begin
          wr_d = 1'b0;
          if (has_next) begin
            bank_d  = next_bank;
            state_d = ST_NEXT;
          end else begin
            wait_d  = 1'b0;
            state_d = ST_IDLE;
            map_we  = boot_a_q[AW-1];
            if (combo_q && (&boot_a_q[13:0])) begin
              combo_d = 1'b0;
              page_d  = PW'(MF2_PAGE);
              base_d  = addr_pg_q + PAGE_BITS'(1);
            end
          end
        end
      end
      ST_NEXT: begin
        if (ce_ref) begin
          wr_d    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      page_q      <= PW'(BAD_PAGE);
      combo_q     <= 1'b0;
      base_q      <= '0;
      addr_pg_q   <= '0;
      dl_q        <= 1'b0;
      load_done_q <= 1'b0;
      wait_q      <= 1'b0;
      wr_q        <= 1'b0;
      boot_a_q    <= '0;
      dout_q      <= '0;
      bank_q      <= '0;
      mirror_q    <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      combo_q     <= combo_d;
      base_q      <= base_d;
      addr_pg_q   <= addr_pg_d;
      dl_q        <= ioctl_download;
      load_done_q <= load_done_d;
      wait_q      <= wait_d;
      wr_q        <= wr_d;
      boot_a_q    <= boot_a_d;
      dout_q      <= dout_d;
      bank_q      <= bank_d;
      mirror_q    <= mirror_d;
    end
  end

  // Presence map survives reset; only its registered read port is cleared.
  always_ff @(posedge clk_sys) begin
    if (map_we && !reset) map_mem[map_waddr] <= 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) map_hit_q <= 1'b0;
    else       map_hit_q <= map_mem[map_addr];
  end

  assign ioctl_wait = wait_q;
  assign boot_wr    = wr_q;
  assign boot_a     = boot_a_q;
  assign boot_bank  = bank_q;
  assign boot_dout  = dout_q;
  assign map_hit    = map_hit_q;
  assign load_done  = load_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_exp_rom_loader.sv
// Directed bench for exp_rom_loader: mirror writes, system ROM slots, combo files,
// malformed extensions, presence map, reset mid-write and download end during a write.
module tb_exp_rom_loader;
  import cpc_loader_pkg::*;

  localparam int W = 32;

  logic        clk_sys, reset, ce_ref;
  logic        ioctl_download, ioctl_wr, ioctl_wait;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index, boot_dout;
  logic [15:0] ioctl_file_ext;
  logic [1:0]  bank_mirror;
  logic        boot_wr, map_hit, load_done;
  logic [22:0] boot_a;
  logic [0:0]  boot_bank;
  logic [7:0]  map_addr;
  state_t      dbg_state;

  logic [W-1:0] exp_q[$];
  int chk_cnt, pass_cnt, ld_cnt, wr_hi;
  logic [1:0] ce_div;

  exp_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_file_ext(ioctl_file_ext),
    .bank_mirror(bank_mirror), .ioctl_wait(ioctl_wait), .boot_wr(boot_wr), .boot_a(boot_a),
    .boot_bank(boot_bank), .boot_dout(boot_dout), .map_addr(map_addr), .map_hit(map_hit),
    .load_done(load_done), .dbg_state(dbg_state)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // One-cycle SDRAM reference strobe every fourth clock.
  initial begin
    ce_ref = 1'b0;
    ce_div = 2'd0;
    forever begin
      @(negedge clk_sys);
      ce_div = ce_div + 2'd1;
      ce_ref = (ce_div == 2'd0);
    end
  end

  // Scoreboard: each new boot_wr pulse must match the head of exp_q.
  initial begin
    logic [W-1:0] got, want;
    logic wr_prev;
    wr_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (load_done) ld_cnt++;
      if (boot_wr) wr_hi++;
      if (boot_wr && !wr_prev) begin
        chk_cnt++;
        got = {boot_bank, boot_a, boot_dout};
        if (exp_q.size() == 0) begin
          $display("FAIL write_unexpected: got %h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) $display("FAIL write_data: got %h expected %h", got, want);
          else pass_cnt++;
        end
      end
      wr_prev = boot_wr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext, input logic [1:0] mir);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_file_ext = ext; bank_mirror = mir; ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (!ioctl_wait) break;
      @(negedge clk_sys);
    end
    chk_cnt++;
    if (ioctl_wait !== 1'b0) $display("FAIL %s_timeout: got wait=%b expected 0", name, ioctl_wait);
    else pass_cnt++;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic exp_wait,
                           input string name);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk_cnt++;
    if (ioctl_wait !== exp_wait) $display("FAIL %s_wait: got %b expected %b", name, ioctl_wait, exp_wait);
    else pass_cnt++;
    wait_idle(name);
  endtask

  task automatic end_dl(input string name);
    int ld0;
    ld0 = ld_cnt;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk_cnt++;
    if (ld_cnt - ld0 !== 1) $display("FAIL %s_load_done: got %0d pulses expected 1", name, ld_cnt - ld0);
    else pass_cnt++;
  endtask

  task automatic read_map(input logic [7:0] a, output logic hit);
    @(negedge clk_sys);
    map_addr = a;
    @(negedge clk_sys);
    hit = map_hit;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk_cnt += 6;
    if (ioctl_wait !== 1'b0) $display("FAIL rst_wait: got %b expected 0", ioctl_wait); else pass_cnt++;
    if (boot_wr !== 1'b0) $display("FAIL rst_boot_wr: got %b expected 0", boot_wr); else pass_cnt++;
    if (load_done !== 1'b0) $display("FAIL rst_load_done: got %b expected 0", load_done); else pass_cnt++;
    if (map_hit !== 1'b0) $display("FAIL rst_map_hit: got %b expected 0", map_hit); else pass_cnt++;
    if (boot_bank !== 1'b0) $display("FAIL rst_bank: got %b expected 0", boot_bank); else pass_cnt++;
    if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d expected 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_mirror_a3();
    int hi0;
    logic hit;
    start_dl(8'd1, 16'h4133, 2'b11);
    hi0 = wr_hi;
    exp_q.push_back({1'b0, 23'h28C000, 8'h55});
    exp_q.push_back({1'b1, 23'h28C000, 8'h55});
    send_byte(25'h0000000, 8'h55, 1'b1, "a3");
    chk_cnt += 3;
    if (wr_hi - hi0 !== 8) $display("FAIL a3_wr_cycles: got %0d expected 8", wr_hi - hi0); else pass_cnt++;
    if (exp_q.size() !== 0) $display("FAIL a3_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    end_dl("a3");
    read_map(8'hA3, hit);
    if (hit !== 1'b0) $display("FAIL a3_map: got %b expected 0", hit); else pass_cnt++;
  endtask

  task automatic test_sysrom();
    int hi0;
    start_dl(8'd0, 16'h4133, 2'b11);
    hi0 = wr_hi;
    exp_q.push_back({1'b1, 23'h400000, 8'hA5});
    send_byte(25'h0014000, 8'hA5, 1'b1, "slot5");
    exp_q.push_back({1'b0, 23'h41C010, 8'h3C});
    send_byte(25'h0008010, 8'h3C, 1'b1, "slot2");
    exp_q.push_back({1'b0, 23'h7FC003, 8'h81});
    send_byte(25'h000C003, 8'h81, 1'b1, "slot3");
    send_byte(25'h0020000, 8'h77, 1'b0, "slot8");
    repeat (20) @(negedge clk_sys);
    chk_cnt += 2;
    if (wr_hi - hi0 !== 12) $display("FAIL sys_wr_cycles: got %0d expected 12", wr_hi - hi0); else pass_cnt++;
    if (exp_q.size() !== 0) $display("FAIL sys_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    end_dl("sys");
  endtask

  task automatic test_combo();
    start_dl(8'd1, 16'h5A30, 2'b01);
    exp_q.push_back({1'b0, 23'h000000, 8'h01});
    send_byte(25'h0000000, 8'h01, 1'b1, "z0_first");
    exp_q.push_back({1'b0, 23'h003FFF, 8'h02});
    send_byte(25'h0003FFF, 8'h02, 1'b1, "z0_last");
    exp_q.push_back({1'b0, 23'h7FC000, 8'h03});
    send_byte(25'h0004000, 8'h03, 1'b1, "z0_mf2");
    exp_q.push_back({1'b0, 23'h7FC001, 8'h04});
    send_byte(25'h0004001, 8'h04, 1'b1, "z0_mf2b");
    chk_cnt++;
    if (exp_q.size() !== 0) $display("FAIL z0_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    end_dl("z0");
  endtask

  task automatic test_bad_ext();
    logic hit;
    read_map(8'hEE, hit);
    chk_cnt++;
    if (hit !== 1'b0) $display("FAIL bad_map_before: got %b expected 0", hit); else pass_cnt++;
    start_dl(8'd1, 16'h783F, 2'b01);
    exp_q.push_back({1'b0, 23'h7B8000, 8'h5A});
    send_byte(25'h0000000, 8'h5A, 1'b1, "bad");
    end_dl("bad");
    read_map(8'hEE, hit);
    chk_cnt += 2;
    if (hit !== 1'b1) $display("FAIL bad_map_after: got %b expected 1", hit); else pass_cnt++;
    if (exp_q.size() !== 0) $display("FAIL bad_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic hit;
    bit seen;
    start_dl(8'd1, 16'h7835, 2'b11);
    exp_q.push_back({1'b0, 23'h794000, 8'hC3});
    @(negedge clk_sys);
    ioctl_addr = 25'h0; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (boot_wr) begin seen = 1'b1; break; end
      @(negedge clk_sys);
    end
    chk_cnt++;
    if (!seen) $display("FAIL rmid_write_start: got boot_wr=0 expected 1"); else pass_cnt++;
    reset = 1'b1; ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk_cnt += 3;
    if (boot_wr !== 1'b0) $display("FAIL rmid_boot_wr: got %b expected 0", boot_wr); else pass_cnt++;
    if (ioctl_wait !== 1'b0) $display("FAIL rmid_wait: got %b expected 0", ioctl_wait); else pass_cnt++;
    if (dbg_state !== ST_IDLE) $display("FAIL rmid_state: got %0d expected 0", dbg_state); else pass_cnt++;
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    read_map(8'hE5, hit);
    chk_cnt++;
    if (hit !== 1'b0) $display("FAIL rmid_map_e5: got %b expected 0", hit); else pass_cnt++;
    read_map(8'hEE, hit);
    chk_cnt += 2;
    if (hit !== 1'b1) $display("FAIL rmid_map_keep: got %b expected 1", hit); else pass_cnt++;
    if (exp_q.size() !== 0) $display("FAIL rmid_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_fall_in_next();
    int hi0, ld0;
    bit seen;
    start_dl(8'd1, 16'h4133, 2'b11);
    hi0 = wr_hi;
    ld0 = ld_cnt;
    exp_q.push_back({1'b0, 23'h290000, 8'h99});
    exp_q.push_back({1'b1, 23'h290000, 8'h99});
    @(negedge clk_sys);
    ioctl_addr = 25'h0004000; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    // A second strobe while busy must be dropped.
    ioctl_addr = 25'h0000100; ioctl_dout = 8'hEE;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dbg_state == ST_NEXT) begin seen = 1'b1; break; end
      @(negedge clk_sys);
    end
    chk_cnt++;
    if (!seen) $display("FAIL fall_reach_next: got state=%0d expected 3", dbg_state); else pass_cnt++;
    ioctl_download = 1'b0;
    wait_idle("fall");
    repeat (4) @(negedge clk_sys);
    chk_cnt += 3;
    if (ld_cnt - ld0 !== 1) $display("FAIL fall_load_done: got %0d pulses expected 1", ld_cnt - ld0); else pass_cnt++;
    if (wr_hi - hi0 !== 8) $display("FAIL fall_wr_cycles: got %0d expected 8", wr_hi - hi0); else pass_cnt++;
    if (exp_q.size() !== 0) $display("FAIL fall_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; ld_cnt = 0; wr_hi = 0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0; ioctl_file_ext = '0; bank_mirror = 2'b00; map_addr = '0;
    test_reset();
    test_mirror_a3();
    test_sysrom();
    test_combo();
    test_bad_ext();
    test_reset_mid();
    test_fall_in_next();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
